load_store_unit: RTL

//   Bus initiator for the word-addressed on-chip RAM (registered read, byte-strobed write).

---
 rtl/lsu_pkg.sv | 12 +
 rtl/lsu_align.sv | 23 ++
 rtl/load_store_unit.sv | 95 +++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types and fault check for the load/store unit.
package lsu_pkg;
    typedef enum logic [1:0] {SIZE_B, SIZE_H, SIZE_W, SIZE_X} size_e;
    typedef enum logic [1:0] {IDLE, ACCESS, DATA, RESP} state_e;

    // Range check is done in 33 bits so 4*RAM never wraps.
    function automatic logic is_fault(input logic [1:0] size, input logic [31:0] addr,
                                      input logic [32:0] limit);
        return size == SIZE_X || (size == SIZE_H && addr[0]) ||
               (size == SIZE_W && addr[1:0] != 2'b00) || {1'b0, addr} >= limit;
    endfunction
endpackage

// File: rtl/lsu_align.sv
// lsu_align: store lane steering and load shift/extend.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    input  logic [1:0]  off,
    input  logic [31:0] store_data,
    input  logic [31:0] ram_data,
    output logic [3:0]  strb,
    output logic [31:0] lane_data,
    output logic [31:0] load_data
);
    logic [15:0] sh;
    always_comb begin
        sh = 16'(ram_data >> {off, 3'b000});
        strb = size == SIZE_B ? 4'b0001 << off : size == SIZE_H ? 4'b0011 << off : 4'b1111;
        lane_data = size == SIZE_B ? {4{store_data[7:0]}} :
                    size == SIZE_H ? {2{store_data[15:0]}} : store_data;
        load_data = size == SIZE_B ? {{24{~is_unsigned & sh[7]}}, sh[7:0]} :
                    size == SIZE_H ? {{16{~is_unsigned & sh[15]}}, sh} : ram_data;
    end
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: sized CPU loads/stores to a word RAM with registered read and byte strobes.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int RAM = 15872
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_fault,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_rdata
);
    localparam logic [32:0] LIMIT = 33'(RAM) << 2;

    state_e state, next;
    logic [1:0] lat_size, lat_off;
    logic lat_unsigned, lat_write, fault;
    logic [3:0] strb;
    logic [31:0] lane_data, load_data;

    // One aligner: steered by the live request in IDLE, by the latched one afterwards.
    lsu_align u_align (
        .size        (state == IDLE ? req_size : lat_size),
        .is_unsigned (lat_unsigned),
        .off         (state == IDLE ? req_addr[1:0] : lat_off),
        .store_data  (req_wdata),
        .ram_data    (mem_rdata),
        .strb        (strb),
        .lane_data   (lane_data),
        .load_data   (load_data)
    );

    always_ff @(posedge clk or posedge reset)
        if (reset) state <= IDLE;
        else state <= next;

    always_comb begin
        fault = is_fault(req_size, req_addr, LIMIT);
        next = state == IDLE   ? (req_valid ? (fault ? RESP : ACCESS) : IDLE) :
               state == ACCESS ? DATA :
               state == DATA   ? RESP : (resp_ready ? IDLE : RESP);
    end

    always_comb req_ready = state == IDLE;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lat_size <= 2'b00;
            lat_off <= 2'b00;
            lat_unsigned <= 1'b0;
            lat_write <= 1'b0;
            mem_addr <= '0;
            mem_wdata <= '0;
            mem_wstrb <= '0;
            resp_rdata <= '0;
            resp_valid <= 1'b0;
            resp_fault <= 1'b0;
        end else begin
            if (state == IDLE && req_valid) begin
                lat_size <= req_size;
                lat_off <= req_addr[1:0];
                lat_unsigned <= req_unsigned;
                lat_write <= req_write;
                if (fault) begin
                    resp_fault <= 1'b1;
                    resp_rdata <= '0;
                    resp_valid <= 1'b1;
                end else begin
                    mem_addr <= {req_addr[31:2], 2'b00};
                    mem_wdata <= lane_data;
                    mem_wstrb <= req_write ? strb : 4'b0000;
                end
            end
            if (state == ACCESS) mem_wstrb <= 4'b0000;
            if (state == DATA) begin
                resp_rdata <= lat_write ? 32'h0 : load_data;
                resp_valid <= 1'b1;
                resp_fault <= 1'b0;
            end
            if (state == RESP && resp_ready) resp_valid <= 1'b0;
        end
    end
endmodule
